// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared core types and sizing for rename/free-list logic
package rv32i_types;
    localparam int TABLE_ENTRIES      = 64;
    localparam int FREELIST_DEPTH     = 32;
    localparam int PREG_W             = $clog2(TABLE_ENTRIES);
    localparam int N_ALLOC_LANES      = 2;
    localparam int N_FREE_LANES       = 2;
    localparam int FREELIST_INIT_BASE = 32;

    typedef logic [PREG_W-1:0] preg_id_t;
endpackage

// File: rtl/free_lane_compact.sv
// rtl/free_lane_compact.sv - packs valid, non-x0 release lanes in lane order
module free_lane_compact
    import rv32i_types::*;
#(
    parameter int N = N_FREE_LANES,
    parameter int W = PREG_W
) (
    input  logic [N-1:0]           lane_valid,
    input  logic [N*W-1:0]         lane_preg,
    output logic [N*W-1:0]         packed_preg,
    output logic [$clog2(N+1)-1:0] packed_cnt
);
    always_comb begin
        int k;
        packed_preg = '0;
        k = 0;
        // ID 0 is the x0 mapping and never re-enters the free pool
        for (int i = 0; i < N; i++) begin
            if (lane_valid[i] && (lane_preg[i*W +: W] != '0)) begin
                packed_preg[k*W +: W] = lane_preg[i*W +: W];
                k = k + 1;
            end
        end
        packed_cnt = ($clog2(N+1))'(k);
    end
endmodule

// File: rtl/phys_free_list_mp.sv
// rtl/phys_free_list_mp.sv - multi-port checkpoint-restorable physical register free list
import rv32i_types::*;

module phys_free_list_mp #(
    parameter int DEPTH     = FREELIST_DEPTH,
    parameter int PREG_W    = rv32i_types::PREG_W,
    parameter int N_DEQ     = N_ALLOC_LANES,
    parameter int N_ENQ     = N_FREE_LANES,
    parameter int INIT_BASE = FREELIST_INIT_BASE
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [$clog2(N_DEQ+1)-1:0]    alloc_cnt,
    output logic                          alloc_ok,
    output logic [N_DEQ*PREG_W-1:0]       alloc_preg,
    input  logic [N_ENQ-1:0]              free_valid,
    input  logic [N_ENQ*PREG_W-1:0]       free_preg,
    input  logic [$clog2(N_DEQ+1)-1:0]    commit_cnt,
    input  logic                          flush,
    output logic [$clog2(DEPTH+1)-1:0]    count,
    output logic                          err
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int AC_W  = $clog2(N_DEQ+1);
    localparam int RC_W  = $clog2(N_ENQ+1);

    logic [PREG_W-1:0]       mem [DEPTH];
    logic [PTR_W-1:0]        head, tail, arch_head, arch_nxt;
    logic [N_ENQ*PREG_W-1:0] rel_preg;
    logic [RC_W-1:0]         rel_cnt;
    logic                    commit_bad, rel_bad, alloc_bad;

    free_lane_compact #(.N(N_ENQ), .W(PREG_W)) u_compact (
        .lane_valid  (free_valid),
        .lane_preg   (free_preg),
        .packed_preg (rel_preg),
        .packed_cnt  (rel_cnt)
    );

    assign count    = CNT_W'(tail - head);
    assign alloc_ok = count >= CNT_W'(N_DEQ);

    for (genvar g = 0; g < N_DEQ; g++) begin : g_lane
        assign alloc_preg[g*PREG_W +: PREG_W] = mem[head[IDX_W-1:0] + IDX_W'(g)];
    end

    // All three checks look at pre-edge pointers; head-arch_head is the in-flight window
    assign commit_bad = PTR_W'(commit_cnt) > (head - arch_head);
    assign arch_nxt   = commit_bad ? arch_head : arch_head + PTR_W'(commit_cnt);
    assign rel_bad    = ({1'b0, count} + (CNT_W+1)'(rel_cnt)) > (CNT_W+1)'(DEPTH);
    assign alloc_bad  = !flush && ((alloc_cnt > AC_W'(N_DEQ)) || (CNT_W'(alloc_cnt) > count));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head      <= '0;
            arch_head <= '0;
            tail      <= {1'b1, {IDX_W{1'b0}}};
            err       <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= PREG_W'(INIT_BASE + i);
            end
        end else begin
            arch_head <= arch_nxt;
            if (!rel_bad) begin
                for (int i = 0; i < N_ENQ; i++) begin
                    if (RC_W'(i) < rel_cnt) begin
                        mem[tail[IDX_W-1:0] + IDX_W'(i)] <= rel_preg[i*PREG_W +: PREG_W];
                    end
                end
                tail <= tail + PTR_W'(rel_cnt);
            end
            // Flush restores to the post-commit architectural head and ignores alloc_cnt
            if (flush) begin
                head <= arch_nxt;
            end else if (!alloc_bad) begin
                head <= head + PTR_W'(alloc_cnt);
            end
            if (commit_bad || rel_bad || alloc_bad) begin
                err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_phys_free_list_mp.sv
// tb/tb_phys_free_list_mp.sv - randomized self-checking bench for phys_free_list_mp
module tb_phys_free_list_mp;
    logic        clk;
    logic        rst;
    logic [1:0]  alloc_cnt;
    logic        alloc_ok;
    logic [11:0] alloc_preg;
    logic [1:0]  free_valid;
    logic [11:0] free_preg;
    logic [1:0]  commit_cnt;
    logic        flush;
    logic [5:0]  count;
    logic        err;

    int checks = 0;
    int errors = 0;

    // Reference model: free IDs in hand-out order, and allocated-but-uncommitted IDs
    int fl[$];
    int infl[$];
    bit err_m;
    int pend_k, pend_p0, pend_p1, pend_c;
    logic [1:0] pend_fv;
    bit pend_f;

    phys_free_list_mp dut (
        .clk        (clk),
        .rst        (rst),
        .alloc_cnt  (alloc_cnt),
        .alloc_ok   (alloc_ok),
        .alloc_preg (alloc_preg),
        .free_valid (free_valid),
        .free_preg  (free_preg),
        .commit_cnt (commit_cnt),
        .flush      (flush),
        .count      (count),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        fl = {};
        infl = {};
        for (int i = 0; i < 32; i++) fl.push_back(32 + i);
        err_m = 1'b0;
    endtask

    task automatic drive(input int k, input logic [1:0] fv, input int p0, input int p1,
                         input int c, input bit f);
        alloc_cnt  = 2'(k);
        free_valid = fv;
        free_preg  = {6'(p1), 6'(p0)};
        commit_cnt = 2'(c);
        flush      = f;
        pend_k = k; pend_fv = fv; pend_p0 = p0; pend_p1 = p1; pend_c = c; pend_f = f;
    endtask

    task automatic tick();
        int rel[$];
        bit cb, rb, ab;
        rel = {};
        if (pend_fv[0] && pend_p0 != 0) rel.push_back(pend_p0);
        if (pend_fv[1] && pend_p1 != 0) rel.push_back(pend_p1);
        cb = pend_c > infl.size();
        rb = (fl.size() + rel.size()) > 32;
        ab = !pend_f && (pend_k > fl.size());
        @(posedge clk);
        if (!cb) repeat (pend_c) void'(infl.pop_front());
        if (!rb) foreach (rel[i]) fl.push_back(rel[i]);
        if (pend_f) begin
            for (int i = infl.size() - 1; i >= 0; i--) fl.push_front(infl[i]);
            infl = {};
        end else if (!ab) begin
            repeat (pend_k) infl.push_back(fl.pop_front());
        end
        if (cb || rb || ab) err_m = 1'b1;
        #1;
        drive(0, 2'b00, 0, 0, 0, 1'b0);
    endtask

    task automatic apply(input int k, input logic [1:0] fv, input int p0, input int p1,
                         input int c, input bit f);
        drive(k, fv, p0, p1, c, f);
        tick();
    endtask

    // Async reset pulse placed mid-cycle, checked before any further clock edge
    task automatic pulse_reset();
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        checks++;
        if (count !== 6'd32 || alloc_preg[5:0] !== 6'd32 || alloc_preg[11:6] !== 6'd33 || err !== 1'b0 || alloc_ok !== 1'b1) begin
            errors++;
            $display("FAIL async_reset: count=%0d lanes=%0d,%0d err=%0d ok=%0d required 32 32,33 0 1",
                     count, alloc_preg[5:0], alloc_preg[11:6], err, alloc_ok);
        end
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++;
        if (count !== 6'd32) begin errors++; $display("FAIL reset_count: got %0d required 32", count); end
        checks++;
        if (alloc_preg[5:0] !== 6'd32 || alloc_preg[11:6] !== 6'd33) begin
            errors++; $display("FAIL reset_lanes: got %0d,%0d required 32,33", alloc_preg[5:0], alloc_preg[11:6]);
        end
        checks++;
        if (alloc_ok !== 1'b1 || err !== 1'b0) begin
            errors++; $display("FAIL reset_flags: ok=%0d err=%0d required 1 0", alloc_ok, err);
        end
    endtask

    task automatic test_drain_and_underflow();
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (alloc_preg[5:0] !== 6'(fl[0]) || alloc_preg[11:6] !== 6'(fl[1])) begin
                errors++; $display("FAIL drain_lanes[%0d]: got %0d,%0d required %0d,%0d", i,
                                   alloc_preg[5:0], alloc_preg[11:6], fl[0], fl[1]);
            end
            if (i == 15) begin
                checks++;
                if (alloc_preg[5:0] !== 6'd62 || alloc_preg[11:6] !== 6'd63) begin
                    errors++; $display("FAIL drain_last: got %0d,%0d required 62,63", alloc_preg[5:0], alloc_preg[11:6]);
                end
            end
            apply(2, 2'b00, 0, 0, 0, 1'b0);
        end
        checks++;
        if (count !== 6'd0 || alloc_ok !== 1'b0 || err !== 1'b0) begin
            errors++; $display("FAIL drained: count=%0d ok=%0d err=%0d required 0 0 0", count, alloc_ok, err);
        end
        apply(1, 2'b00, 0, 0, 0, 1'b0);
        checks++;
        if (err !== 1'b1 || count !== 6'd0) begin
            errors++; $display("FAIL underflow: err=%0d count=%0d required 1 0", err, count);
        end
        // Underflowing alloc alongside a release: release lands, not bypassed this cycle
        drive(1, 2'b11, 40, 41, 0, 1'b0);
        #1;
        checks++;
        if (alloc_preg[5:0] === 6'd40) begin
            errors++; $display("FAIL no_bypass: got %0d required anything but 40", alloc_preg[5:0]);
        end
        tick();
        checks++;
        if (alloc_preg[5:0] !== 6'd40 || alloc_preg[11:6] !== 6'd41 || count !== 6'd2 || err !== 1'b1) begin
            errors++; $display("FAIL release_visible: got %0d,%0d count=%0d err=%0d required 40,41 2 1",
                               alloc_preg[5:0], alloc_preg[11:6], count, err);
        end
    endtask

    task automatic test_zero_drop();
        apply(0, 2'b11, 0, 45, 0, 1'b0);
        checks++;
        if (count !== 6'd3) begin errors++; $display("FAIL zero_drop_count: got %0d required 3", count); end
        apply(2, 2'b00, 0, 0, 0, 1'b0);
        checks++;
        if (alloc_preg[5:0] !== 6'd45 || count !== 6'd1) begin
            errors++; $display("FAIL zero_drop_id: got %0d count=%0d required 45 1", alloc_preg[5:0], count);
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) apply(2, 2'b00, 0, 0, 0, 1'b0);
        apply(0, 2'b00, 0, 0, 2, 1'b0);
        apply(0, 2'b00, 0, 0, 0, 1'b1);
        checks++;
        if (count !== 6'd30 || alloc_preg[5:0] !== 6'd34 || alloc_preg[11:6] !== 6'd35 || err !== 1'b0) begin
            errors++; $display("FAIL flush_restore: count=%0d lanes=%0d,%0d err=%0d required 30 34,35 0",
                               count, alloc_preg[5:0], alloc_preg[11:6], err);
        end
        apply(2, 2'b00, 0, 0, 0, 1'b0);
        apply(2, 2'b00, 0, 0, 0, 1'b1);
        checks++;
        if (count !== 6'd30 || alloc_preg[5:0] !== 6'd34 || err !== 1'b0) begin
            errors++; $display("FAIL flush_beats_alloc: count=%0d lane0=%0d err=%0d required 30 34 0",
                               count, alloc_preg[5:0], err);
        end
        apply(2, 2'b00, 0, 0, 0, 1'b0);
        apply(0, 2'b00, 0, 0, 2, 1'b1);
        checks++;
        if (count !== 6'd28 || alloc_preg[5:0] !== 6'(fl[0]) || alloc_preg[5:0] !== 6'd36) begin
            errors++; $display("FAIL flush_with_commit: count=%0d lane0=%0d required 28 36", count, alloc_preg[5:0]);
        end
    endtask

    task automatic test_wrap();
        int prev0, prev1, a0, a1;
        prev0 = int'(alloc_preg[5:0]);
        prev1 = int'(alloc_preg[11:6]);
        apply(2, 2'b00, 0, 0, 0, 1'b0);
        for (int i = 0; i < 48; i++) begin
            a0 = int'(alloc_preg[5:0]);
            a1 = int'(alloc_preg[11:6]);
            checks++;
            if (a0 !== fl[0] || a1 !== fl[1] || count !== 6'd30 || err !== 1'b0) begin
                errors++; $display("FAIL wrap[%0d]: lanes=%0d,%0d count=%0d err=%0d required %0d,%0d 30 0",
                                   i, a0, a1, count, err, fl[0], fl[1]);
            end
            apply(2, 2'b11, prev0, prev1, 2, 1'b0);
            prev0 = a0;
            prev1 = a1;
        end
    endtask

    task automatic test_random();
        int k, c, p0, p1, n, occ;
        logic [1:0] fv;
        bit f;
        for (int cyc = 0; cyc < 400; cyc++) begin
            checks++;
            if (count !== 6'(fl.size()) || alloc_ok !== (fl.size() >= 2) || err !== err_m) begin
                errors++; $display("FAIL rand_state[%0d]: count=%0d ok=%0d err=%0d required %0d %0d %0d",
                                   cyc, count, alloc_ok, err, fl.size(), fl.size() >= 2, err_m);
            end
            for (int l = 0; l < 2 && l < fl.size(); l++) begin
                checks++;
                if (alloc_preg[l*6 +: 6] !== 6'(fl[l])) begin
                    errors++; $display("FAIL rand_lane%0d[%0d]: got %0d required %0d", l, cyc, alloc_preg[l*6 +: 6], fl[l]);
                end
            end
            f  = ($urandom % 12) == 0;
            k  = $urandom % 3;
            c  = $urandom_range(0, infl.size() < 2 ? infl.size() : 2);
            if (($urandom % 25) == 0 && infl.size() < 2) c = infl.size() + 1;
            fv = 2'($urandom);
            p0 = $urandom % 64;
            p1 = $urandom % 64;
            n  = int'(fv[0] && p0 != 0) + int'(fv[1] && p1 != 0);
            occ = fl.size() + infl.size() - ((c <= infl.size()) ? c : 0);
            // A release that fits by count but would overwrite in-flight entries is not exercised
            if (fl.size() + n <= 32 && occ + n > 32) fv = 2'b00;
            apply(k, fv, p0, p1, c, f);
            if (cyc == 200) pulse_reset();
        end
    endtask

    initial begin
        rst = 1'b0;
        drive(0, 2'b00, 0, 0, 0, 1'b0);
        model_reset();
        #12;
        rst = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_drain_and_underflow();
        test_zero_drop();
        pulse_reset();
        test_flush();
        pulse_reset();
        test_wrap();
        pulse_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
